// File: rtl/term_defs_pkg.sv
// Shared terminal geometry, cell format and block-writer state encoding.
package term_defs;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] BLANK_CELL = 16'h0720;

    // CELLS at address width and at the one-bit-wider source-sum width
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W:0]   CELLS_W = (ADDR_W + 1)'(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/text_block_writer.sv
// Bulk fill/copy engine for the text cell RAM write port: issues one cell per
// clock (read at p0), writes it one clock later (p1) from RAM data or the fill value.
module text_block_writer
    import term_defs::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_start,
    input  logic [ADDR_W-1:0] wr_begin,
    input  logic [ADDR_W-1:0] wr_end,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_offset,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_r;
    logic [ADDR_W-1:0] off_r;
    logic [DATA_W-1:0] data_r;

    logic [ADDR_W-1:0] dst_p0, dst_p1;
    logic              copy_p0, copy_p1;
    logic              vld_p0, vld_p1;

    logic [ADDR_W-1:0] start_end;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] iss_off;
    logic [ADDR_W:0]   iss_src;
    logic              iss_copy;
    logic              issue;

    // The first cell is issued straight from the wr_* inputs so reads begin
    // the cycle after start is sampled.
    always_comb begin
        start_end = (wr_end > CELLS_A) ? CELLS_A : wr_end;
        iss_addr  = (state == IDLE) ? wr_begin : cur;
        iss_off   = (state == IDLE) ? wr_offset : off_r;
        iss_src   = {1'b0, iss_addr} + {1'b0, iss_off};
        iss_copy  = (iss_off != '0) && (iss_src < CELLS_W);
        issue     = ((state == IDLE) && wr_start && (wr_begin < start_end)) ||
                    ((state == RUN) && (cur != end_r));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cur       <= '0;
            end_r     <= '0;
            off_r     <= '0;
            data_r    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_raddr <= '0;
            dst_p0    <= '0;
            copy_p0   <= 1'b0;
            vld_p0    <= 1'b0;
            dst_p1    <= '0;
            copy_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            // ---- p0 -> p1: issued cell moves to the write stage ----
            dst_p1  <= dst_p0;
            copy_p1 <= copy_p0;
            vld_p1  <= vld_p0;

            // ---- issue stage p0 ----
            done      <= 1'b0;
            vld_p0    <= issue;
            copy_p0   <= issue && iss_copy;
            mem_rd_en <= issue && iss_copy;
            mem_raddr <= (issue && iss_copy) ? iss_src[ADDR_W-1:0] : '0;
            if (issue) begin
                dst_p0 <= iss_addr;
                cur    <= iss_addr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (wr_start) begin
                        end_r  <= start_end;
                        off_r  <= wr_offset;
                        data_r <= wr_data;
                        if (issue) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cur == end_r) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- write stage p1 ----
    assign mem_we    = vld_p1;
    assign mem_waddr = dst_p1;
    assign mem_wdata = copy_p1 ? mem_rdata : data_r;

endmodule

// File: tb/tb_text_block_writer.sv
// Bench for text_block_writer: sync RAM model, table-driven and random
// operations checked against a snapshot-based reference of the block write.
module tb_text_block_writer;
    import term_defs::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_start;
    logic [ADDR_W-1:0] wr_begin;
    logic [ADDR_W-1:0] wr_end;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_offset;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    text_block_writer dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_start  (wr_start),
        .wr_begin  (wr_begin),
        .wr_end    (wr_end),
        .wr_data   (wr_data),
        .wr_offset (wr_offset),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram     [0:2047];
    logic [DATA_W-1:0] exp_ram [0:2047];
    int                wtag    [0:2047];

    int wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0, oob_cnt = 0, dup_cnt = 0;
    int op_id = 0;
    logic        init_req = 1'b0;
    logic        init_kind = 1'b0;
    logic [15:0] init_seed = 16'd1;

    // RAM model plus activity counters; sole writer of ram and the counters
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 2048; i++)
                ram[i] <= init_kind ? 16'(i * init_seed + 13) : 16'(i);
        end else begin
            if (mem_rd_en) begin
                mem_rdata <= ram[mem_raddr];
                rd_cnt    <= rd_cnt + 1;
            end
            if (mem_we) begin
                wr_cnt <= wr_cnt + 1;
                if (int'(mem_waddr) >= CELLS) begin
                    oob_cnt <= oob_cnt + 1;
                end else begin
                    if (wtag[mem_waddr] == op_id) dup_cnt <= dup_cnt + 1;
                    wtag[mem_waddr] <= op_id;
                    ram[mem_waddr]  <= mem_wdata;
                end
            end
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic init_ram(input logic kind);
        @(negedge clk);
        init_kind = kind;
        init_seed = 16'($urandom_range(1, 65535)) | 16'd1;
        init_req  = 1'b1;
        @(negedge clk);
        init_req  = 1'b0;
    endtask

    // Reference: each destination cell takes the pre-operation value of the
    // cell off ahead, or the fill value when off is 0 or the source is off-screen.
    task automatic model_op(input int b, input int e, input int off, input logic [15:0] d,
                            output int n, output int r);
        int ec;
        ec = (e > CELLS) ? CELLS : e;
        n  = (b < ec) ? ec - b : 0;
        r  = 0;
        for (int i = 0; i < 2048; i++) exp_ram[i] = ram[i];
        for (int i = b; i < b + n; i++) begin
            if (off != 0 && i + off < CELLS) begin
                exp_ram[i] = ram[i + off];
                r++;
            end else begin
                exp_ram[i] = d;
            end
        end
    endtask

    task automatic scramble_inputs();
        wr_begin  = 11'($urandom);
        wr_end    = 11'($urandom);
        wr_offset = 11'($urandom);
        wr_data   = 16'($urandom);
    endtask

    task automatic pulse_start(input int b, input int e, input int off, input logic [15:0] d);
        @(negedge clk);
        wr_start  = 1'b1;
        wr_begin  = 11'(b);
        wr_end    = 11'(e);
        wr_offset = 11'(off);
        wr_data   = d;
        @(negedge clk);
        wr_start  = 1'b0;
        scramble_inputs();
    endtask

    task automatic chk_ram(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 2048; i++)
            if (ram[i] !== exp_ram[i]) bad++;
        chk({name, " ram_cells_wrong"}, bad, 0);
    endtask

    // Run one operation, wait for done (bounded) and check every observable
    task automatic do_op(input string name, input int b, input int e, input int off,
                         input logic [15:0] d, input int ew, input int er, input int el,
                         input int eb);
        int n, r, lat, w0, r0, b0, d0, o0, u0;
        model_op(b, e, off, d, n, r);
        op_id++;
        w0 = wr_cnt; r0 = rd_cnt; b0 = busy_cnt; d0 = done_cnt; o0 = oob_cnt; u0 = dup_cnt;
        pulse_start(b, e, off, d);
        lat = 1;
        while (!done && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " done_latency"}, lat, el);
        @(negedge clk);
        chk({name, " done_width"}, int'(done), 0);
        chk({name, " done_pulses"}, done_cnt - d0, 1);
        chk({name, " writes"}, wr_cnt - w0, ew);
        chk({name, " reads"}, rd_cnt - r0, er);
        chk({name, " busy_cycles"}, busy_cnt - b0, eb);
        chk({name, " oob_writes"}, oob_cnt - o0, 0);
        chk({name, " dup_writes"}, dup_cnt - u0, 0);
        chk_ram(name);
    endtask

    typedef struct {
        int          b, e, off;
        logic [15:0] d;
        logic        ramp;
        int          ew, er, el, eb;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int w0, b0, d0, n, r;

        resetn = 1'b0; wr_start = 1'b0; wr_begin = '0; wr_end = '0;
        wr_offset = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset rd_en", int'(mem_rd_en), 0);
        chk("reset we", int'(mem_we), 0);
        chk("reset raddr", int'(mem_raddr), 0);
        chk("reset waddr", int'(mem_waddr), 0);
        chk("reset wdata", int'(mem_wdata), 0);
        resetn = 1'b1;

        //           b     e     off   data      ramp  ew    er    el    eb
        tbl[0] = '{0,    1920, 80,   16'h0000, 1'b1, 1920, 1920, 1922, 1921};
        tbl[1] = '{1920, 2000, 0,    16'h0720, 1'b0, 80,   0,    82,   81};
        tbl[2] = '{1900, 2000, 80,   16'h1234, 1'b0, 100,  20,   102,  101};
        tbl[3] = '{1990, 2047, 5,    16'hBEEF, 1'b0, 10,   5,    12,   11};
        tbl[4] = '{5,    5,    3,    16'h1111, 1'b0, 0,    0,    1,    0};
        tbl[5] = '{10,   3,    0,    16'h2222, 1'b0, 0,    0,    1,    0};
        tbl[6] = '{7,    8,    3,    16'hAAAA, 1'b0, 1,    1,    3,    2};
        tbl[7] = '{0,    10,   2047, 16'h5555, 1'b0, 10,   0,    12,   11};
        tbl[8] = '{2010, 2047, 1,    16'h3333, 1'b0, 0,    0,    1,    0};
        tbl[9] = '{0,    4,    1999, 16'h4444, 1'b0, 4,    1,    6,    5};

        for (int k = 0; k < 10; k++) begin
            init_ram(!tbl[k].ramp);
            do_op($sformatf("tbl%0d", k), tbl[k].b, tbl[k].e, tbl[k].off, tbl[k].d,
                  tbl[k].ew, tbl[k].er, tbl[k].el, tbl[k].eb);
        end

        // Starts during a scroll and during its done cycle are dropped
        init_ram(1'b0);
        model_op(0, 1920, 80, 16'h0000, n, r);
        op_id++;
        w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
        pulse_start(0, 1920, 80, 16'h0000);
        for (int j = 1; j < 20; j++) begin
            repeat (20) @(negedge clk);
            pulse_start(j, 50 + j, 0, 16'hFFFF);
        end
        for (int t = 0; t < 4000 && !done; t++) @(negedge clk);
        chk("busy_starts done_seen", int'(done), 1);
        wr_start = 1'b1; wr_begin = 11'd0; wr_end = 11'd50; wr_offset = '0; wr_data = 16'hFFFF;
        @(negedge clk);
        wr_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_starts writes", wr_cnt - w0, 1920);
        chk("busy_starts busy_cycles", busy_cnt - b0, 1921);
        chk("busy_starts done_pulses", done_cnt - d0, 1);
        chk_ram("busy_starts");

        // Reset in the middle of a scroll
        init_ram(1'b1);
        pulse_start(0, 1920, 80, 16'h0000);
        repeat (98) @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        w0 = wr_cnt; b0 = busy_cnt; d0 = done_cnt;
        repeat (4) @(negedge clk);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset we", int'(mem_we), 0);
        chk("midreset rd_en", int'(mem_rd_en), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset writes_after", wr_cnt - w0, 0);
        chk("midreset busy_after", busy_cnt - b0, 0);
        chk("midreset done_after", done_cnt - d0, 0);
        do_op("after_reset", 100, 300, 7, 16'h1357, 200, 200, 202, 201);

        // Random operations against the reference
        for (int k = 0; k < 30; k++) begin
            int b, e, off, sel, el, eb;
            logic [15:0] d;
            b   = $urandom_range(0, 2047);
            e   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047)
                                              : b + $urandom_range(0, 300);
            if (e > 2047) e = 2047;
            sel = $urandom_range(0, 3);
            off = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 100)
                : (sel == 2) ? $urandom_range(0, 2047) : 80;
            d   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) init_ram(1'b1);
            model_op(b, e, off, d, n, r);
            el = (n > 0) ? n + 2 : 1;
            eb = (n > 0) ? n + 1 : 0;
            do_op($sformatf("rnd%0d", k), b, e, off, d, n, r, el, eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_block_writer.md
Name: text_block_writer

Overview:
- Bulk-write engine for the terminal's text cell RAM.
- On a one-cycle start pulse it walks a cell range [wr_begin, wr_end) and writes each cell with either a constant fill value or a copy of the cell wr_offset positions ahead.
- This single operation implements clear-line, clear-screen and scroll-up.
- It sits between the terminal command logic (which drives wr_*) and the write port of the dual-port text RAM; the VGA scan-out owns the other RAM port.

Parameters:
COLS, 80, characters per row
ROWS, 25, rows per screen
CELLS, COLS*ROWS (2000), number of text cells
ADDR_W, 11, cell address width (must satisfy 2**ADDR_W >= CELLS)
DATA_W, 16, cell width (char code plus attribute)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
wr_start  in  1  one-cycle start pulse; sampled only in IDLE
wr_begin  in  ADDR_W  first destination cell (inclusive)
wr_end  in  ADDR_W  last destination cell (exclusive)
wr_data  in  DATA_W  fill value
wr_offset  in  ADDR_W  source distance; 0 = pure fill
busy  out  1  operation in progress
done  out  1  one-cycle pulse when the operation completes
mem_rd_en  out  1  RAM read strobe
mem_raddr  out  ADDR_W  RAM read address
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_rd_en
mem_we  out  1  RAM write strobe
mem_waddr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; busy, done, mem_rd_en and mem_we all 0; address and data outputs 0.
  - Reset mid-operation aborts immediately; no further writes occur.
- IDLE, wr_start=1:
  - Latch begin, end, data and offset.
  - Clamp the latched end to CELLS if wr_end > CELLS.
  - If begin >= clamped end: stay in IDLE; done=1 for the next cycle; busy stays 0; no RAM access.
  - Otherwise: cur=begin, go to RUN.
- RUN (busy=1), per cycle for cell cur:
  - src = cur + offset, computed ADDR_W+1 bits wide so it cannot wrap.
  - Copy mode (offset != 0 and src < CELLS): mem_rd_en=1, mem_raddr=src.
  - Fill mode (offset = 0, or src >= CELLS): mem_rd_en=0.
  - Stage register captures dst=cur and the mode. Then cur <= cur+1.
  - When cur = end-1 has been issued, go to DRAIN.
- Write stage (cycle after issue), driven from the stage register:
  - mem_we=1, mem_waddr=dst.
  - mem_wdata = mem_rdata in copy mode, latched data in fill mode.
  - Sustains one cell per clock.
  - Copying proceeds in ascending address order with offset >= 0, so every read precedes any overwrite of its source.
- DRAIN: the last write occurs; next state DONE.
- DONE: done=1 for one cycle; busy=0; return to IDLE.
- Timing:
  - For a start sampled at cycle 0 with N = end-begin > 0: reads at cycles 1..N, writes at cycles 2..N+1.
  - busy is high for cycles 1..N+1.
  - done is high at cycle N+2.
  - Exactly N writes, no duplicates.
- wr_start is ignored while busy or in DONE; it is never queued.
- Changes on the wr_* inputs after the start is sampled have no effect.
- Writes never target addresses >= CELLS.

Decomposition:
- Shared header/package term_defs holds:
  - COLS, ROWS, CELLS, ADDR_W, DATA_W
  - the default blank-cell constant BLANK_CELL = 16'h0720
  - state encodings IDLE, RUN, DRAIN, DONE
- No sub-module: the FSM plus the one-entry stage register is a single natural unit of about 150 lines.

Test Plan:
- Scroll: RAM[i]=i, start with begin=0, end=1920, offset=80, data=0.
  - RAM[i]=i+80 for i<1920; RAM[1920..1999] unchanged.
  - 1920 writes; done at cycle 1922 after start; busy high for 1921 cycles.
- Clear last row: begin=1920, end=2000, offset=0, data=16'h0720.
  - RAM[1920..1999]=16'h0720; mem_rd_en never asserted; 80 writes.
- Source overflow: begin=1900, end=2000, offset=80.
  - RAM[1900..1919] = old RAM[1980..1999]; RAM[1920..1999]=wr_data.
  - Also end=2047 clamps: no write to addresses >= 2000.
- Empty range: begin=end=5, and separately begin=10, end=3.
  - done pulse 1 cycle later, busy never high, zero RAM accesses.
- Start while busy: 20 back-to-back starts spaced 22 cycles during a scroll.
  - Only starts sampled in IDLE launch an operation.
  - Write count = sum of the accepted ranges.
- Reset mid-operation: resetn=0 at cycle 100 of a scroll.
  - No mem_we from the next cycle on; busy=0, done=0.
  - A new start after reset completes normally.
